// File: rtl/eth_crc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_crc_pkg
//  Description : Shared constants and the per-byte update function for the
//                reflected IEEE 802.3 CRC-32 engine.
//  Revision    : 1.0  initial release
// ============================================================================
package eth_crc_pkg;

    // Reflected form of polynomial 0x04C11DB7
    localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB88320;

    // Un-inverted state left after a frame followed by its own FCS
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    // One byte through the LSB-first reflected CRC-32
    function automatic logic [31:0] crc32_byte(input logic [31:0] state,
                                               input logic [7:0]  data);
        logic [31:0] v;
        v = state ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            v = v[0] ? ((v >> 1) ^ CRC32_POLY_REFLECTED) : (v >> 1);
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc32_byte_step.sv
`default_nettype none
// ============================================================================
//  Module      : crc32_byte_step
//  Description : Combinational single-byte CRC-32 step; passes the incoming
//                CRC through untouched when its lane is not enabled.
//  Revision    : 1.0  initial release
// ============================================================================
module crc32_byte_step
    import eth_crc_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_byte,
    input  logic        enable,
    output logic [31:0] crc_out
);

    // Skipped lanes contribute nothing, so a disabled step is a wire
    always_comb begin
        crc_out = crc_in;
        if (enable) begin
            crc_out = crc32_byte(crc_in, data_byte);
        end
    end

endmodule
`default_nettype wire

// File: rtl/eth_crc32.sv
`default_nettype none
// ============================================================================
//  Module      : eth_crc32
//  Description : Running Ethernet CRC-32 over up to SLICE_LENGTH bytes per
//                clock, qualified by a per-lane valid mask. Lane 0 is first
//                on the wire. Optional output inversion and output register.
//  Revision    : 1.0  initial release
// ============================================================================
module eth_crc32
    import eth_crc_pkg::*;
#(
    parameter int          SLICE_LENGTH    = 4,
    parameter logic [31:0] INITIAL_CRC     = 32'hFFFFFFFF,
    parameter int          INVERT_OUTPUT   = 1,
    parameter int          REGISTER_OUTPUT = 0
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [8*SLICE_LENGTH-1:0] in_data,
    input  logic [SLICE_LENGTH-1:0]   in_valid,
    output logic [31:0]               out_crc
);

    localparam logic [31:0] c_invert_mask = (INVERT_OUTPUT != 0) ? 32'hFFFFFFFF : 32'h00000000;

    logic [31:0] r_state;
    logic [31:0] w_chain [0:SLICE_LENGTH];
    logic [31:0] w_state_out;

    assign w_chain[0] = r_state;

    // Lanes are folded in ascending order, each step feeding the next
    generate
        for (genvar gi = 0; gi < SLICE_LENGTH; gi++) begin : g_lane
            crc32_byte_step u_step (
                .crc_in    (w_chain[gi]),
                .data_byte (in_data[8*gi +: 8]),
                .enable    (in_valid[gi]),
                .crc_out   (w_chain[gi+1])
            );
        end
    endgenerate

    // Running CRC state; reset wins over any data presented in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INITIAL_CRC;
        end else begin
            r_state <= w_chain[SLICE_LENGTH];
        end
    end

    assign w_state_out = r_state ^ c_invert_mask;

    generate
        if (REGISTER_OUTPUT != 0) begin : g_reg_out
            logic [31:0] r_out;

            // Extra pipeline stage after the state, reloaded on reset as well
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_out <= INITIAL_CRC ^ c_invert_mask;
                end else begin
                    r_out <= w_state_out;
                end
            end

            assign out_crc = r_out;
        end else begin : g_comb_out
            assign out_crc = w_state_out;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_eth_crc32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_crc32
//  Description : Directed, table-driven bench for eth_crc32. Two instances
//                share stimulus: dut_a with defaults, dut_b with
//                REGISTER_OUTPUT=1 and INVERT_OUTPUT=0.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_eth_crc32;

    logic        clk;
    logic        reset;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [31:0] out_crc_a;
    logic [31:0] out_crc_b;

    int n_tests;
    int n_fail;

    typedef struct {
        logic        rst;
        logic [31:0] data;
        logic [3:0]  valid;
        logic        chk_a;
        logic [31:0] exp_a;
        logic        chk_b;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs[$];

    eth_crc32 #(
        .SLICE_LENGTH    (4),
        .INITIAL_CRC     (32'hFFFFFFFF),
        .INVERT_OUTPUT   (1),
        .REGISTER_OUTPUT (0)
    ) dut_a (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .out_crc  (out_crc_a)
    );

    eth_crc32 #(
        .SLICE_LENGTH    (4),
        .INITIAL_CRC     (32'hFFFFFFFF),
        .INVERT_OUTPUT   (0),
        .REGISTER_OUTPUT (1)
    ) dut_b (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .out_crc  (out_crc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [31:0] d, input logic [3:0] v,
                       input logic ca, input logic [31:0] ea,
                       input logic cb, input logic [31:0] eb);
        vec_t t;
        t.rst = r; t.data = d; t.valid = v;
        t.chk_a = ca; t.exp_a = ea; t.chk_b = cb; t.exp_b = eb;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, clock it in, sample at the following negedge
    task automatic cycle(input logic r, input logic [31:0] d, input logic [3:0] v);
        reset    = r;
        in_data  = d;
        in_valid = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] held;
        reset    = 1'b1;
        in_data  = 32'h0;
        in_valid = 4'h0;
        n_tests  = 0;
        n_fail   = 0;

        // rst, data, valid, chk_a, exp_a, chk_b, exp_b
        // Reset state
        add(1, 32'h00000000, 4'h0, 1, 32'h00000000, 1, 32'hFFFFFFFF);
        // "123456789": two full words then "9" in lane 0
        add(0, 32'h34333231, 4'hF, 0, 32'h0,        1, 32'hFFFFFFFF);
        add(0, 32'h38373635, 4'hF, 0, 32'h0,        0, 32'h0);
        add(0, 32'h00000039, 4'h1, 1, 32'hCBF43926, 0, 32'h0);
        add(0, 32'hA5A5A5A5, 4'h0, 1, 32'hCBF43926, 1, 32'h340BC6D9);
        // Reset together with valid data
        add(1, 32'hDEADBEEF, 4'hF, 1, 32'h00000000, 1, 32'hFFFFFFFF);
        // Four zero bytes
        add(0, 32'h00000000, 4'hF, 1, 32'h2144DF1C, 0, 32'h0);
        // Mask 0111 over "123"
        add(1, 32'h00000000, 4'h0, 1, 32'h00000000, 0, 32'h0);
        add(0, 32'h00333231, 4'h7, 1, 32'h884863D2, 0, 32'h0);
        add(0, 32'h00000000, 4'h0, 1, 32'h884863D2, 1, 32'h77B79C2D);
        // "123" one byte per cycle
        add(1, 32'h00000000, 4'h0, 1, 32'h00000000, 0, 32'h0);
        add(0, 32'h00000031, 4'h1, 0, 32'h0,        0, 32'h0);
        add(0, 32'h00000032, 4'h1, 0, 32'h0,        0, 32'h0);
        add(0, 32'h00000033, 4'h1, 1, 32'h884863D2, 0, 32'h0);
        add(0, 32'hFFFFFFFF, 4'h0, 1, 32'h884863D2, 1, 32'h77B79C2D);
        // Mask 1110: garbage lane 0 ignored
        add(1, 32'h00000000, 4'h0, 1, 32'h00000000, 0, 32'h0);
        add(0, 32'h333231AA, 4'hE, 1, 32'h884863D2, 0, 32'h0);
        // Mask 0101 then 0001
        add(1, 32'h00000000, 4'h0, 1, 32'h00000000, 0, 32'h0);
        add(0, 32'hEE32EE31, 4'h5, 0, 32'h0,        0, 32'h0);
        add(0, 32'hEEEEEE33, 4'h1, 1, 32'h884863D2, 0, 32'h0);
        // Frame + FCS (26 39 F4 CB), misaligned across words
        add(1, 32'h00000000, 4'h0, 1, 32'h00000000, 0, 32'h0);
        add(0, 32'h34333231, 4'hF, 0, 32'h0,        0, 32'h0);
        add(0, 32'h38373635, 4'hF, 0, 32'h0,        0, 32'h0);
        add(0, 32'hF4392639, 4'hF, 0, 32'h0,        0, 32'h0);
        add(0, 32'h000000CB, 4'h1, 1, 32'h2144DF1C, 0, 32'h0);
        add(0, 32'h00000000, 4'h0, 1, 32'h2144DF1C, 1, 32'hDEBB20E3);
        // Reset mid-frame leaves no residue
        add(0, 32'h34333231, 4'hF, 0, 32'h0,        0, 32'h0);
        add(1, 32'h12345678, 4'hB, 1, 32'h00000000, 1, 32'hFFFFFFFF);
        add(0, 32'h00000000, 4'hF, 1, 32'h2144DF1C, 0, 32'h0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].data, vecs[i].valid);
            if (vecs[i].chk_a) check($sformatf("vec%0d_a", i), out_crc_a, vecs[i].exp_a);
            if (vecs[i].chk_b) check($sformatf("vec%0d_b", i), out_crc_b, vecs[i].exp_b);
        end

        // Hold: in_valid low for 5 cycles with changing data
        cycle(1, 32'h0, 4'h0);
        cycle(0, 32'h34333231, 4'hF);
        cycle(0, 32'h38373635, 4'hF);
        cycle(0, 32'h00000039, 4'h1);
        held = 32'hCBF43926;
        for (int k = 0; k < 5; k++) begin
            cycle(0, $urandom, 4'h0);
            check($sformatf("hold%0d_a", k), out_crc_a, held);
        end
        check("hold_b", out_crc_b, 32'h340BC6D9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_crc32.md
# eth_crc32

Parameterised Ethernet CRC-32 engine: accepts up to SLICE_LENGTH bytes per clock under a per-byte valid mask and keeps a running CRC. It sits beside the TX MAC datapath and computes the FCS over destination MAC through pad. The MAC appends out_crc least-significant byte first.

## Interface
- SLICE_LENGTH, 4: bytes processed per cycle (1..8).
- INITIAL_CRC, 32'hFFFFFFFF: value loaded into the CRC state on reset.
- INVERT_OUTPUT, 1: when 1, out_crc = state ^ 32'hFFFFFFFF; when 0, out_crc = state.
- REGISTER_OUTPUT, 0: when 1, out_crc passes through one extra output register.
- clk  in  1  rising-edge clock; the block's only clock.
- reset  in  1  synchronous, active-high; loads the state with INITIAL_CRC.
- in_data  in  8*SLICE_LENGTH  byte lanes; lane k = in_data[8k+7:8k]; lane 0 is first on the wire.
- in_valid  in  SLICE_LENGTH  per-lane enable; bit k qualifies lane k.
- out_crc  out  32  current CRC (possibly inverted and/or registered).

## Operation
- Algorithm: reflected CRC-32, IEEE 802.3.
  - Polynomial 0x04C11DB7; reflected constant 0xEDB88320.
  - LSB-first bit order within each byte.
- Per-byte update: state = state ^ byte; then 8 times: state = state[0] ? (state>>1) ^ 0xEDB88320 : state>>1.
- Per cycle without reset: visit lanes 0..SLICE_LENGTH-1 in ascending order. Apply the byte update only for lanes whose in_valid bit is 1.
  - Invalid lanes are skipped, not treated as zero.
  - Any mask is legal, including non-contiguous ones such as 4'b1110, 4'b0111 and 4'b0101.
- in_valid all zero: state holds.
- reset high: state <= INITIAL_CRC. This takes priority over any in_valid/in_data in the same cycle.
- No frame delimiting inside the block. The user asserts reset between frames.
- Reset may be asserted mid-frame. Partial results are discarded with no residue.

## Timing
- State register updates on the rising edge of clk.
- REGISTER_OUTPUT=0: out_crc is combinational from the state register.
  - It reflects all bytes accepted up to and including the most recent edge.
  - Latency from in_valid to out_crc is 1 cycle.
- REGISTER_OUTPUT=1: out_crc is a register fed from the state, giving 2 cycles latency.
  - That register is also loaded on reset.
- Reset value of out_crc with defaults: 32'h00000000, i.e. INITIAL_CRC ^ 32'hFFFFFFFF.
  - With INVERT_OUTPUT=0 the reset value is INITIAL_CRC.
  - With REGISTER_OUTPUT=1 the reset value holds from the first edge after reset rises.
- Throughput: SLICE_LENGTH bytes per cycle, every cycle. No stalls and no backpressure.
- Combinational path: SLICE_LENGTH chained byte steps. Slicing-by-N tables are a permitted alternative if the results are bit-identical.

## Structure
- Package eth_crc_pkg holds:
  - localparam CRC32_POLY_REFLECTED = 32'hEDB88320;
  - CRC32_RESIDUE = 32'hDEBB20E3;
  - function crc32_byte(state, byte) implementing the per-byte update.
- Sub-module crc32_byte_step: purely combinational (crc_in, data_byte, enable) -> crc_out.
  - Instantiated SLICE_LENGTH times in a generate chain.
  - A disabled step passes crc_in through unchanged.
- The top holds only the state register, the optional output register and the invert XOR.

## Test plan
- ASCII "123456789", SLICE_LENGTH=4, defaults:
  - Stimulus: two full words, then one cycle with in_valid=4'b0001 carrying "9".
  - Required: out_crc = 32'hCBF43926.
- Four zero bytes in one word, valid 4'b1111, after reset:
  - Required: out_crc = 32'h2144DF1C.
- Mask skipping:
  - Stimulus: word {8'h00,"3","2","1"} with valid 4'b0111.
  - Required: equals the result of feeding "123" one byte per cycle.
  - Stimulus: word with valid 4'b1110.
  - Required: lane 0 is ignored.
- Frame plus appended FCS (out_crc bytes LSB first) fed back through the block:
  - Required: state = 32'hDEBB20E3, so out_crc = 32'h2144DF1C.
- Reset priority and hold:
  - Stimulus: reset asserted together with valid data.
  - Required: out_crc = 32'h00000000 on the next cycle.
  - Stimulus: in_valid=0 for 5 cycles.
  - Required: out_crc unchanged.
- REGISTER_OUTPUT=1, INVERT_OUTPUT=0:
  - Required: the "123456789" result appears one cycle later than with REGISTER_OUTPUT=0.
  - Required value: 32'h340BC6D9 (un-inverted).
